// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C request arbiter.
package i2c_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

    localparam logic READ  = 1'b1;
    localparam logic WRITE = 1'b0;

    localparam int DEF_TIMEOUT_CYCLES = 4096;

endpackage

// File: rtl/i2c_rr_pick.sv
// Combinational round-robin picker: the first set request strictly after
// last_grant, wrapping around, wins.
module i2c_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDW-1:0]     idx,
    output logic               any
);

    // Scan offsets 1..NUM_REQ from the last winner so it is considered last.
    always_comb begin
        int cand;
        cand  = 0;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(last_grant) + k) % NUM_REQ;
            if (!any && req[cand]) begin
                any         = 1'b1;
                idx         = IDW'(cand);
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_req_arbiter.sv
// Round-robin sharing of one I2C master among NUM_REQ single-byte requesters.
// Optional watchdog on the master is enabled by defining I2C_ARB_TIMEOUT_EN.
//
//   state | meaning
//   IDLE  | waiting for a request while the master is not busy; accepts here
//   ISSUE | m_start pulse to the master, watchdog cleared
//   WAIT  | waiting for m_done (or watchdog expiry)
//   RESP  | rsp_valid pulse to the winner, round-robin pointer advanced
module i2c_req_arbiter
    import i2c_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int IDW            = $clog2(NUM_REQ),
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ-1:0]   req_rw,
    input  logic [8*NUM_REQ-1:0] req_wdata,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [NUM_REQ-1:0]   rsp_valid,
    output logic [7:0]           rsp_rdata,
    output logic                 rsp_err,
    output logic [IDW-1:0]       grant_id,
    output logic                 m_start,
    output logic                 m_rw,
    output logic [7:0]           m_wdata,
    output logic                 m_abort,
    input  logic                 m_busy,
    input  logic                 m_done,
    input  logic [7:0]           m_rdata
);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_cfg_check
        $error("i2c_req_arbiter: unsupported parameter set");
    end

    arb_state_t           state_q, state_d;
    logic [IDW-1:0]       grant_q;
    logic [IDW-1:0]       last_grant_q;
    logic                 m_rw_q;
    logic [7:0]           m_wdata_q;
    logic [7:0]           rdata_q;
    logic                 err_q;
    logic                 accept;
    logic                 to_hit;

    logic [NUM_REQ-1:0]   pick_grant;
    logic [IDW-1:0]       pick_idx;
    logic                 pick_any;

    i2c_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_pick (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .grant      (pick_grant),
        .idx        (pick_idx),
        .any        (pick_any)
    );

`ifdef I2C_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    logic [TW-1:0] wdog_q;

    // Watchdog: cleared while issuing, counts every cycle spent in WAIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog_q <= '0;
        end else if (state_q == ST_ISSUE) begin
            wdog_q <= '0;
        end else if (state_q == ST_WAIT) begin
            wdog_q <= wdog_q + TW'(1);
        end
    end

    assign to_hit  = (state_q == ST_WAIT) && (wdog_q == TW'(TIMEOUT_CYCLES - 1));
    // A completion on the expiry cycle takes priority over the abort.
    assign m_abort = to_hit && !m_done;
`else
    assign to_hit  = 1'b0;
    assign m_abort = 1'b0;
`endif

    // Next-state logic; accept is gated by rst so req_ready stays low in reset.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_any && !m_busy && !rst) begin
                    accept  = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (m_done || to_hit) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State register, command latch, response capture and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= IDW'(NUM_REQ - 1);
            m_rw_q       <= WRITE;
            m_wdata_q    <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                grant_q   <= pick_idx;
                m_rw_q    <= req_rw[pick_idx];
                m_wdata_q <= req_wdata[8*int'(pick_idx) +: 8];
            end
            if (state_q == ST_WAIT && m_done) begin
                rdata_q <= (m_rw_q == READ) ? m_rdata : 8'h00;
                err_q   <= 1'b0;
            end else if (to_hit) begin
                rdata_q <= 8'h00;
                err_q   <= 1'b1;
            end
            if (state_q == ST_RESP) begin
                last_grant_q <= grant_q;
            end
        end
    end

    assign req_ready = accept ? pick_grant : '0;
    assign grant_id  = accept ? pick_idx : grant_q;
    assign rsp_valid = (state_q == ST_RESP) ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << grant_q) : '0;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign m_start   = (state_q == ST_ISSUE);
    assign m_rw      = m_rw_q;
    assign m_wdata   = m_wdata_q;

endmodule
